// File: rtl/i2s_pkg.sv
// Shared constants, types and helpers for the I2S receive path.
package i2s_pkg;

    localparam logic CH_LEFT  = 1'b0;
    localparam logic CH_RIGHT = 1'b1;

    localparam int unsigned DELAY_I2S = 1;
    localparam int unsigned DELAY_LJ  = 0;

    typedef enum logic {StUnlocked, StLocked} lock_state_e;

    // Wide enough to count to WORD_SIZE+1, the saturation point.
    function automatic int unsigned cnt_width(input int unsigned word_size);
        return $clog2(word_size + 2);
    endfunction

endpackage

// File: rtl/i2s_rx_deser.sv
// Serial-to-parallel shift register with a saturating per-slot bit counter.
module i2s_rx_deser
    import i2s_pkg::*;
#(
    parameter int unsigned WORD_SIZE = 32,
    parameter int unsigned CNT_W     = cnt_width(WORD_SIZE)
) (
    input  logic                 bck,
    input  logic                 rst_n,
    input  logic                 din,
    input  logic                 sample,
    input  logic                 clear,
    output logic [WORD_SIZE-1:0] word,
    output logic [CNT_W-1:0]     count,
    output logic [WORD_SIZE-1:0] word_app,
    output logic [CNT_W-1:0]     count_app
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WORD_SIZE);
    localparam logic [CNT_W-1:0] SAT_CNT  = CNT_W'(WORD_SIZE + 1);

    logic [WORD_SIZE-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    always_comb begin
        // word_app/count_app: current slot with this cycle's din appended
        count_app = (cnt_q == SAT_CNT) ? cnt_q : cnt_q + CNT_W'(1);
        word_app  = (cnt_q < FULL_CNT) ? {shift_q[WORD_SIZE-2:0], din} : shift_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        if (clear) begin
            shift_d = sample ? WORD_SIZE'(din) : '0;
            cnt_d   = sample ? CNT_W'(1) : '0;
        end else if (sample) begin
            shift_d = word_app;
            cnt_d   = count_app;
        end
    end

    always_ff @(posedge bck) begin
        if (!rst_n) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    assign word  = shift_q;
    assign count = cnt_q;

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: lrck edge detect, lock, channel steering and left/right pairing.
module i2s_rx
    import i2s_pkg::*;
#(
    parameter int unsigned WORD_SIZE   = 32,
    parameter int unsigned SAMPLE_SIZE = 24,
    parameter int unsigned DATA_DELAY  = 1
) (
    input  logic                          bck,
    input  logic                          rst_n,
    input  logic                          lrck,
    input  logic                          din,
    output logic [WORD_SIZE-1:0]          l_word,
    output logic [WORD_SIZE-1:0]          r_word,
    output logic signed [SAMPLE_SIZE-1:0] l_sample,
    output logic signed [SAMPLE_SIZE-1:0] r_sample,
    output logic                          l_valid,
    output logic                          r_valid,
    output logic                          frame_valid,
    output logic                          locked,
    output logic                          frame_err
);

    localparam int unsigned      CNT_W    = cnt_width(WORD_SIZE);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WORD_SIZE);
    localparam logic             LJ       = (DATA_DELAY == DELAY_LJ);

    lock_state_e          state_q, state_d;
    logic                 lrck_d_q, left_ok_q, left_ok_d;
    logic [WORD_SIZE-1:0] l_word_q, l_word_d, r_word_q, r_word_d;
    logic                 l_valid_q, l_valid_d, r_valid_q, r_valid_d;
    logic                 frame_valid_q, frame_valid_d, frame_err_q, frame_err_d;

    logic                 lrck_edge, slot_end, deser_sample, word_ok;
    logic [WORD_SIZE-1:0] deser_word, deser_word_app, done_word;
    logic [CNT_W-1:0]     deser_count, deser_count_app, done_cnt;

    assign lrck_edge = (lrck != lrck_d_q);
    assign slot_end  = (state_q == StLocked) && lrck_edge;
    // In left-justified mode the edge bit is the new slot's MSB; in I2S mode it is the old LSB.
    assign deser_sample = lrck_edge ? LJ : (state_q == StLocked);

    i2s_rx_deser #(
        .WORD_SIZE (WORD_SIZE),
        .CNT_W     (CNT_W)
    ) u_deser (
        .bck       (bck),
        .rst_n     (rst_n),
        .din       (din),
        .sample    (deser_sample),
        .clear     (lrck_edge),
        .word      (deser_word),
        .count     (deser_count),
        .word_app  (deser_word_app),
        .count_app (deser_count_app)
    );

    assign done_word = LJ ? deser_word : deser_word_app;
    assign done_cnt  = LJ ? deser_count : deser_count_app;
    assign word_ok   = (done_cnt >= FULL_CNT);

    always_comb begin
        state_d       = (state_q == StUnlocked && lrck_edge) ? StLocked : state_q;
        left_ok_d     = left_ok_q;
        l_word_d      = l_word_q;
        r_word_d      = r_word_q;
        l_valid_d     = 1'b0;
        r_valid_d     = 1'b0;
        frame_valid_d = 1'b0;
        frame_err_d   = 1'b0;
        if (slot_end) begin
            frame_err_d = (done_cnt != FULL_CNT);
            left_ok_d   = (lrck_d_q == CH_LEFT) && word_ok;
            if (word_ok) begin
                if (lrck_d_q == CH_LEFT) begin
                    l_word_d  = done_word;
                    l_valid_d = 1'b1;
                end else begin
                    r_word_d      = done_word;
                    r_valid_d     = 1'b1;
                    frame_valid_d = left_ok_q;
                end
            end
        end
    end

    always_ff @(posedge bck) begin
        if (!rst_n) begin
            state_q       <= StUnlocked;
            lrck_d_q      <= 1'b0;
            left_ok_q     <= 1'b0;
            l_word_q      <= '0;
            r_word_q      <= '0;
            l_valid_q     <= 1'b0;
            r_valid_q     <= 1'b0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            lrck_d_q      <= lrck;
            left_ok_q     <= left_ok_d;
            l_word_q      <= l_word_d;
            r_word_q      <= r_word_d;
            l_valid_q     <= l_valid_d;
            r_valid_q     <= r_valid_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
        end
    end

    assign l_word      = l_word_q;
    assign r_word      = r_word_q;
    assign l_sample    = l_word_q[WORD_SIZE-1 -: SAMPLE_SIZE];
    assign r_sample    = r_word_q[WORD_SIZE-1 -: SAMPLE_SIZE];
    assign l_valid     = l_valid_q;
    assign r_valid     = r_valid_q;
    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;
    assign locked      = (state_q == StLocked);

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: one Philips-mode and one left-justified instance on a shared bus.
module tb_i2s_rx;
    import i2s_pkg::*;

    logic bck = 1'b0, rst_n = 1'b0, lrck = 1'b0, din = 1'b0;

    logic [31:0]        l_word1, r_word1, l_word0, r_word0;
    logic signed [23:0] l_sample1, r_sample1, l_sample0, r_sample0;
    logic l_valid1, r_valid1, frame_valid1, locked1, frame_err1;
    logic l_valid0, r_valid0, frame_valid0, locked0, frame_err0;

    int passed = 0, total = 0;
    int n_l = 0, n_r = 0, n_f = 0, n_e = 0, n_le = 0, cyc = 0, last_l = 0, last_r = 0;
    logic pending = 1'b0;
    bit   lj_mode = 1'b0;

    always #5 bck = ~bck;

    i2s_rx #(.WORD_SIZE(32), .SAMPLE_SIZE(24), .DATA_DELAY(DELAY_I2S)) dut1 (
        .bck(bck), .rst_n(rst_n), .lrck(lrck), .din(din),
        .l_word(l_word1), .r_word(r_word1), .l_sample(l_sample1), .r_sample(r_sample1),
        .l_valid(l_valid1), .r_valid(r_valid1), .frame_valid(frame_valid1),
        .locked(locked1), .frame_err(frame_err1)
    );

    i2s_rx #(.WORD_SIZE(32), .SAMPLE_SIZE(24), .DATA_DELAY(DELAY_LJ)) dut0 (
        .bck(bck), .rst_n(rst_n), .lrck(lrck), .din(din),
        .l_word(l_word0), .r_word(r_word0), .l_sample(l_sample0), .r_sample(r_sample0),
        .l_valid(l_valid0), .r_valid(r_valid0), .frame_valid(frame_valid0),
        .locked(locked0), .frame_err(frame_err0)
    );

    // Pulse counters for the Philips instance, sampled mid-cycle.
    always @(negedge bck) begin
        cyc++;
        if (l_valid1 === 1'b1) begin n_l++; last_l = cyc; end
        if (r_valid1 === 1'b1) begin n_r++; last_r = cyc; end
        if (frame_valid1 === 1'b1) n_f++;
        if (frame_err1 === 1'b1) n_e++;
        if (l_valid1 === 1'b1 && frame_err1 === 1'b1) n_le++;
    end

    // bits holds the slot MSB-first in its low n bits; Philips mode delays everything one bck.
    task automatic send_slot(input logic ch, input logic [39:0] bits, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge bck);
            lrck = ch;
            if (lj_mode) din = bits[n-1-k];
            else         din = (k == 0) ? pending : bits[n-k];
        end
        pending = bits[0];
    endtask

    task automatic send_word(input logic ch, input logic [31:0] w);
        send_slot(ch, {8'h00, w}, 32);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        lrck  = 1'b0;
        for (int i = 0; i < 10; i++) begin @(negedge bck); din = i[0]; end
        @(negedge bck);
        total++;
        if ({l_word1, r_word1, l_sample1, r_sample1, l_valid1, r_valid1, frame_valid1,
             frame_err1} !== '0) $display("FAIL reset_outputs: got %h/%h required 0",
                                         l_word1, r_word1);
        else passed++;
        total++;
        if (locked1 !== 1'b0) $display("FAIL reset_locked: got %b required 0", locked1);
        else passed++;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin @(negedge bck); din = ~din; end
        total++;
        if (locked1 !== 1'b0) $display("FAIL prelock_locked: got %b required 0", locked1);
        else passed++;
        total++;
        if (n_l + n_r + n_e !== 0) $display("FAIL prelock_pulses: got %0d required 0",
                                            n_l + n_r + n_e);
        else passed++;
    endtask

    task automatic test_lock();
        send_word(CH_RIGHT, 32'h12345678);
        total++;
        if (locked1 !== 1'b1) $display("FAIL lock_locked: got %b required 1", locked1);
        else passed++;
        send_word(CH_LEFT, 32'h1FFFFF00);
        total++;
        if (r_word1 !== 32'h12345678) $display("FAIL lock_r_word: got %h required 12345678",
                                               r_word1);
        else passed++;
        total++;
        if (n_r !== 1 || n_l !== 0 || n_f !== 0 || n_e !== 0)
            $display("FAIL lock_pulses: got r%0d l%0d f%0d e%0d required r1 l0 f0 e0",
                     n_r, n_l, n_f, n_e);
        else passed++;
    endtask

    task automatic test_loopback();
        int l0, r0, f0, e0;
        l0 = n_l; r0 = n_r; f0 = n_f; e0 = n_e;
        send_word(CH_RIGHT, 32'hE0000100);
        total++;
        if (l_sample1 !== 24'h1FFFFF) $display("FAIL loop_l_sample_pos: got %h required 1fffff",
                                               l_sample1);
        else passed++;
        send_word(CH_LEFT, 32'hE0000100);
        send_word(CH_RIGHT, 32'h1FFFFF00);
        send_word(CH_LEFT, 32'h1FFFFF00);
        total++;
        if (l_word1 !== 32'hE0000100) $display("FAIL loop_l_word: got %h required e0000100",
                                               l_word1);
        else passed++;
        total++;
        if (l_sample1 !== 24'hE00001) $display("FAIL loop_l_sample_neg: got %h required e00001",
                                               l_sample1);
        else passed++;
        total++;
        if (r_word1 !== 32'h1FFFFF00) $display("FAIL loop_r_word: got %h required 1fffff00",
                                               r_word1);
        else passed++;
        total++;
        if (r_sample1 !== 24'h1FFFFF) $display("FAIL loop_r_sample: got %h required 1fffff",
                                               r_sample1);
        else passed++;
        total++;
        if (n_l - l0 !== 2 || n_r - r0 !== 2 || n_f - f0 !== 2 || n_e - e0 !== 0)
            $display("FAIL loop_pulses: got l%0d r%0d f%0d e%0d required l2 r2 f2 e0",
                     n_l - l0, n_r - r0, n_f - f0, n_e - e0);
        else passed++;
        total++;
        if (last_r - last_l !== 32) $display("FAIL loop_spacing: got %0d required 32",
                                             last_r - last_l);
        else passed++;
    endtask

    task automatic test_short_slot();
        int l0, r0, f0, e0;
        send_word(CH_RIGHT, 32'hE0000100);
        send_slot(CH_LEFT, 40'h00000ABCDE, 20);
        l0 = n_l; r0 = n_r; f0 = n_f; e0 = n_e;
        send_word(CH_RIGHT, 32'hCAFEF00D);
        total++;
        if (n_e - e0 !== 1 || n_l - l0 !== 0)
            $display("FAIL short_err: got e%0d l%0d required e1 l0", n_e - e0, n_l - l0);
        else passed++;
        total++;
        if (l_word1 !== 32'h1FFFFF00) $display("FAIL short_l_hold: got %h required 1fffff00",
                                               l_word1);
        else passed++;
        send_word(CH_LEFT, 32'h0F0F0F0F);
        total++;
        if (n_r - r0 !== 1 || n_f - f0 !== 0)
            $display("FAIL short_next_r: got r%0d f%0d required r1 f0", n_r - r0, n_f - f0);
        else passed++;
        total++;
        if (r_word1 !== 32'hCAFEF00D) $display("FAIL short_r_word: got %h required cafef00d",
                                               r_word1);
        else passed++;
    endtask

    task automatic test_long_slot();
        int e0, le0, f0;
        send_word(CH_RIGHT, 32'h11111111);
        send_slot(CH_LEFT, {4'h0, 32'hA5A5A5A5, 4'hF}, 36);
        e0 = n_e; le0 = n_le; f0 = n_f;
        send_word(CH_RIGHT, 32'h22222222);
        total++;
        if (l_word1 !== 32'hA5A5A5A5) $display("FAIL long_l_word: got %h required a5a5a5a5",
                                               l_word1);
        else passed++;
        total++;
        if (n_le - le0 !== 1 || n_e - e0 !== 1)
            $display("FAIL long_valid_err: got le%0d e%0d required le1 e1",
                     n_le - le0, n_e - e0);
        else passed++;
        send_word(CH_LEFT, 32'h00000000);
        total++;
        if (n_f - f0 !== 1) $display("FAIL long_frame: got %0d required 1", n_f - f0);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int l0, r0, e0;
        l0 = n_l; r0 = n_r; e0 = n_e;
        send_slot(CH_RIGHT, 40'h1, 1);
        send_slot(CH_LEFT, 40'h0, 1);
        send_slot(CH_RIGHT, 40'h1, 1);
        send_word(CH_LEFT, 32'h3C3C3C3C);
        total++;
        if (n_e - e0 !== 3) $display("FAIL b2b_err: got %0d required 3", n_e - e0);
        else passed++;
        total++;
        if (n_l - l0 !== 1 || n_r - r0 !== 0)
            $display("FAIL b2b_valid: got l%0d r%0d required l1 r0", n_l - l0, n_r - r0);
        else passed++;
        total++;
        if (l_word1 !== 32'h00000000) $display("FAIL b2b_l_word: got %h required 0", l_word1);
        else passed++;
    endtask

    task automatic test_left_justified();
        lj_mode = 1'b1;
        send_word(CH_RIGHT, 32'h00000000);
        send_word(CH_LEFT, 32'h80000001);
        send_word(CH_RIGHT, 32'h7FFFFFFE);
        send_word(CH_LEFT, 32'h00000000);
        total++;
        if (l_word0 !== 32'h80000001) $display("FAIL lj_l_word: got %h required 80000001",
                                               l_word0);
        else passed++;
        total++;
        if (r_word0 !== 32'h7FFFFFFE) $display("FAIL lj_r_word: got %h required 7ffffffe",
                                               r_word0);
        else passed++;
        total++;
        if (l_sample0 !== 24'h800000) $display("FAIL lj_l_sample: got %h required 800000",
                                               l_sample0);
        else passed++;
        total++;
        if (r_sample0 !== 24'h7FFFFF) $display("FAIL lj_r_sample: got %h required 7fffff",
                                               r_sample0);
        else passed++;
        lj_mode = 1'b0;
    endtask

    task automatic test_mid_reset();
        int l0, r0, e0;
        send_slot(CH_RIGHT, 40'h2AA, 10);
        rst_n = 1'b0;
        lrck  = 1'b0;
        for (int i = 0; i < 10; i++) begin @(negedge bck); din = i[1]; end
        total++;
        if ({l_word1, r_word1, l_valid1, r_valid1, frame_err1, locked1, locked0} !== '0)
            $display("FAIL midrst_outputs: got %h/%h lk%b required 0", l_word1, r_word1,
                     locked1);
        else passed++;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin @(negedge bck); din = ~din; end
        total++;
        if (locked1 !== 1'b0) $display("FAIL midrst_locked: got %b required 0", locked1);
        else passed++;
        l0 = n_l; r0 = n_r; e0 = n_e;
        send_word(CH_RIGHT, 32'h0BADF00D);
        send_word(CH_LEFT, 32'h00000000);
        total++;
        if (r_word1 !== 32'h0BADF00D) $display("FAIL midrst_r_word: got %h required 0badf00d",
                                               r_word1);
        else passed++;
        total++;
        if (n_r - r0 !== 1 || n_l - l0 !== 0 || n_e - e0 !== 0)
            $display("FAIL midrst_pulses: got r%0d l%0d e%0d required r1 l0 e0",
                     n_r - r0, n_l - l0, n_e - e0);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_lock();
        test_loopback();
        test_short_slot();
        test_long_slot();
        test_back_to_back();
        test_left_justified();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/i2s_rx.md
Name: i2s_rx

Overview:
- I2S receiver: deserializes a stereo I2S stream (bck/lrck/din) back into parallel left and right words.
- It is the receive end of the i2s_tx link. The testbench uses it to loop back test-generator output and check it.
- It is also the audio input stage ahead of the DSP datapath.
- It runs entirely in the bck domain. It detects lrck edges, counts bits per slot, flags framing errors and pairs left/right words into frames.

Parameters:
- WORD_SIZE, 32, bits per channel slot and width of the parallel word outputs (8..32).
- SAMPLE_SIZE, 24, width of the signed sample outputs; the sample is the MSB-aligned top of the word (SAMPLE_SIZE <= WORD_SIZE).
- DATA_DELAY, 1, bck cycles between an lrck edge and the MSB. 1 = Philips I2S, 0 = left-justified. Only 0 and 1 are legal.

Ports:
- bck, input, 1, bit clock. All state updates on posedge bck; the transmitter drives on negedge.
- rst_n, input, 1, reset: synchronous, active-low.
- lrck, input, 1, word select: 0 = left slot, 1 = right slot.
- din, input, 1, serial data, MSB first.
- l_word, output, WORD_SIZE, last complete left word.
- r_word, output, WORD_SIZE, last complete right word.
- l_sample, output, SAMPLE_SIZE, signed, equal to l_word[WORD_SIZE-1 -: SAMPLE_SIZE].
- r_sample, output, SAMPLE_SIZE, signed, equal to r_word[WORD_SIZE-1 -: SAMPLE_SIZE].
- l_valid, output, 1, one-bck pulse when l_word updates.
- r_valid, output, 1, one-bck pulse when r_word updates.
- frame_valid, output, 1, one-bck pulse coinciding with r_valid when the immediately preceding left slot was also valid.
- locked, output, 1, high once the first lrck edge after reset has been seen.
- frame_err, output, 1, one-bck pulse when a slot ends with a bit count other than WORD_SIZE.

Behaviour:
- Reset (rst_n low at posedge bck): all outputs 0. Clears the shift register, bit counter, lrck_d, left_ok flag and locked. Reset may occur at any bit; the partial word is dropped with no valid and no err.
- Edge detect: lrck_d <= lrck every posedge. An edge is the posedge where lrck != lrck_d. The channel that just ended is lrck_d.
- Unlocked state:
  - Ignore din and counts until the first edge.
  - At the first edge, set locked = 1 and start counting.
  - The slot ending at the first edge is discarded silently.
- Capture, DATA_DELAY=1:
  - Bits are sampled on the posedges after an edge up to and including the next edge posedge; the next edge posedge carries the LSB.
  - The word completes on that edge posedge, with the sampled bit appended.
- Capture, DATA_DELAY=0:
  - The edge posedge carries the MSB of the new slot.
  - The previous word completes using the bits sampled up to the posedge before the edge.
- Bit counter:
  - Saturates at WORD_SIZE+1.
  - Only the first WORD_SIZE bits of a slot enter the shift register; later bits are ignored.
- Slot completion:
  - Count == WORD_SIZE: load l_word or r_word on the same posedge (assembled word includes the final bit) and pulse l_valid or r_valid.
  - Count < WORD_SIZE: word discarded, no valid, frame_err pulse.
  - Count > WORD_SIZE: first WORD_SIZE bits delivered with valid, plus a frame_err pulse.
- Frame pairing:
  - left_ok is set on a valid left completion and cleared on any other completion.
  - frame_valid = r_valid && left_ok.
- Hold: l_word and r_word hold their values between updates.
- lrck changes on consecutive posedges: each edge ends a slot, so these are short slots and produce frame_err pulses.

Decomposition:
- i2s_pkg:
  - CH_LEFT=1'b0 and CH_RIGHT=1'b1.
  - DELAY_I2S=1 and DELAY_LJ=0.
  - A shared function for the bit-counter width, $clog2(WORD_SIZE+2).
- One sub-module, i2s_rx_deser: shift register plus saturating bit counter with clear/complete inputs; reports word and count.
- The top level holds edge detect, the lock FSM, channel steering and pairing.

Test Plan:
- Loopback with i2s_test_gen (WORD_SIZE=32, SAMPLE_SIZE=24):
  - After lock, l_word/r_word take only 32'h1FFFFF00 (sample +2097151) or 32'hE0000100 (sample -2097151).
  - l_valid and r_valid alternate every 32 bck cycles; frame_valid every 64; frame_err never.
- Hold rst_n low for 10 bck cycles mid-slot, then release:
  - All outputs stay 0 and locked stays 0 until the first lrck edge.
  - The first valid appears at the end of the first full slot after that edge.
- Short slot (lrck toggles after 20 bits):
  - frame_err pulses once, no l_valid, l_word keeps its previous value.
  - The next right slot gives r_valid=1 with frame_valid=0.
- Long slot (36 bck cycles):
  - Word 32'hA5A5A5A5 followed by 4 extra bits of 1 yields l_word=32'hA5A5A5A5, l_valid=1 and frame_err=1 on the same cycle.
- DATA_DELAY=0 with a left-justified stimulus carrying L=32'h80000001 and R=32'h7FFFFFFE:
  - Exact words received.
  - l_sample = 24'h800000 and r_sample = 24'h7FFFFF.
